// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: port limits, default widths,
// the per-grant operation type and the round-robin pointer advance helper.
package mem_arb_pkg;

  localparam int MEM_ARB_MAX_PORTS = 8;
  localparam int MEM_ARB_IDX_W     = 3;
  localparam int MEM_ARB_DEF_AW    = 16;
  localparam int MEM_ARB_DEF_DW    = 16;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_RD,
    OP_WR
  } mem_op_t;

  // Pointer value after granting port g out of n ports: g+1, wrapping to 0.
  function automatic logic [MEM_ARB_IDX_W-1:0] next_ptr(input logic [MEM_ARB_IDX_W-1:0] g,
                                                         input int n);
    if (int'(g) >= n - 1) begin
      return '0;
    end
    return g + MEM_ARB_IDX_W'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Rotating-priority encoder: picks the first eligible port at or after ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_valid
);

  // candidate index ptr+i reduced modulo N; one extra bit holds the overflow
  logic [PW:0] cand;

  // Scan N candidates starting at ptr; the first eligible one wins.
  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
      if (!gnt_valid && elig[cand[PW-1:0]]) begin
        gnt_valid               = 1'b1;
        gnt_idx                 = cand[PW-1:0];
        gnt_oh[cand[PW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter sharing one single-ported synchronous SRAM, one access per
// cycle. Grant is combinational in cycle t (drives mem_*), rdy pulses in t+1.
// Handshake: a port holds req_rd/req_wr (and addr/wdata) until it sees its rdy
// pulse; the port is masked in its rdy cycle so a held request is never served
// twice. Write wins when req_rd and req_wr are both high.
// Optional build macro MEM_ARB_PRIO0_EN: port 0 wins whenever eligible and the
// round-robin pointer then rotates among ports 1..NPORTS-1 only.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int AW     = MEM_ARB_DEF_AW,
  parameter int DW     = MEM_ARB_DEF_DW
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic [NPORTS*AW-1:0] req_addr,
  input  logic [NPORTS*DW-1:0] req_wdata,
  input  logic [NPORTS-1:0]    req_rd,
  input  logic [NPORTS-1:0]    req_wr,
  output logic [NPORTS-1:0]    rdy,
  output logic [DW-1:0]        rd_data,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic                 mem_re,
  output logic                 mem_we,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int PW = $clog2(NPORTS);

  logic [NPORTS-1:0] rdy_q, rdy_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  mem_op_t           op_q, op_d;
  logic [DW-1:0]     rd_hold_q, rd_hold_d;

  logic [NPORTS-1:0] elig;
  logic [NPORTS-1:0] rr_elig;
  logic [NPORTS-1:0] rr_oh;
  logic [PW-1:0]     rr_idx;
  logic              rr_valid;

  logic [NPORTS-1:0] gnt_oh;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_valid;
  logic              gnt_adv;
  mem_op_t           gnt_op;

  assign elig = (req_rd | req_wr) & ~rdy_q;

`ifdef MEM_ARB_PRIO0_EN
  assign rr_elig = {elig[NPORTS-1:1], 1'b0};
`else
  assign rr_elig = elig;
`endif

  rr_pick #(
    .N  (NPORTS),
    .PW (PW)
  ) u_rr_pick (
    .elig      (rr_elig),
    .ptr       (ptr_q),
    .gnt_oh    (rr_oh),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  // Final grant: round-robin result, overridden by port 0 in priority builds.
  always_comb begin
    gnt_oh    = rr_oh;
    gnt_idx   = rr_idx;
    gnt_valid = rr_valid;
    gnt_adv   = rr_valid;
`ifdef MEM_ARB_PRIO0_EN
    if (elig[0]) begin
      gnt_oh    = NPORTS'(1);
      gnt_idx   = '0;
      gnt_valid = 1'b1;
      gnt_adv   = 1'b0;
    end
`endif
  end

  // Memory-side drive for the granted port; reset forces the SRAM idle.
  always_comb begin
    gnt_op = OP_NONE;
    if (gnt_valid && reset_n) begin
      gnt_op = req_wr[gnt_idx] ? OP_WR : OP_RD;
    end
    mem_addr  = req_addr[gnt_idx*AW +: AW];
    mem_wdata = req_wdata[gnt_idx*DW +: DW];
    mem_re    = (gnt_op == OP_RD);
    mem_we    = (gnt_op == OP_WR);
  end

  // Next-state: rdy for the granted port, op record, pointer advance, read hold.
  always_comb begin
    rdy_d     = (gnt_op != OP_NONE) ? gnt_oh : '0;
    op_d      = gnt_op;
    ptr_d     = ptr_q;
    rd_hold_d = rd_hold_q;
    if (gnt_op != OP_NONE && gnt_adv) begin
      ptr_d = PW'(next_ptr(MEM_ARB_IDX_W'(gnt_idx), NPORTS));
    end
    if (op_q == OP_RD) begin
      rd_hold_d = mem_rdata;
    end
  end

  // Read data is live from the SRAM in a read's rdy cycle, held otherwise.
  assign rd_data = (op_q == OP_RD) ? mem_rdata : rd_hold_q;
  assign rdy     = rdy_q;

  // State registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q     <= '0;
      ptr_q     <= '0;
      op_q      <= OP_NONE;
      rd_hold_q <= '0;
    end else begin
      rdy_q     <= rdy_d;
      ptr_q     <= ptr_d;
      op_q      <= op_d;
      rd_hold_q <= rd_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (NPORTS=3, AW=DW=16) with a behavioural
// 1-cycle-latency SRAM. Inputs change at the falling edge; outputs are
// sampled 1 time unit later. Expected values are hand-derived constants;
// the MEM_ARB_PRIO0_EN build selects the priority-mode expectations.
module tb_mem_arbiter;

  localparam int NP = 3;
  localparam int AW = 16;
  localparam int DW = 16;

`ifdef MEM_ARB_PRIO0_EN
  localparam logic [15:0] T4_ADDR_A = 16'h0201;
  localparam logic [15:0] T4_ADDR_B = 16'h0200;
  localparam logic [2:0]  T4_RDY_A  = 3'b001;
  localparam logic [2:0]  T4_RDY_B  = 3'b100;
  localparam int          T4_FIRST  = 0;
  localparam logic [15:0] PC_ADDR_A = 16'h0300;
  localparam int          PC_FIRST  = 0;
  localparam logic [15:0] T5_ADDR_5 = 16'h0500;
  localparam logic [15:0] T5_ADDR_6 = 16'h0102;
  localparam logic [2:0]  T5_RDY_6  = 3'b001;
`else
  localparam logic [15:0] T4_ADDR_A = 16'h0200;
  localparam logic [15:0] T4_ADDR_B = 16'h0201;
  localparam logic [2:0]  T4_RDY_A  = 3'b100;
  localparam logic [2:0]  T4_RDY_B  = 3'b001;
  localparam int          T4_FIRST  = 2;
  localparam logic [15:0] PC_ADDR_A = 16'h0301;
  localparam int          PC_FIRST  = 1;
  localparam logic [15:0] T5_ADDR_5 = 16'h0102;
  localparam logic [15:0] T5_ADDR_6 = 16'h0500;
  localparam logic [2:0]  T5_RDY_6  = 3'b100;
`endif

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic reset_n;
  always #5 sys_clk = ~sys_clk;

  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]    req_rd;
  logic [NP-1:0]    req_wr;
  logic [NP-1:0]    rdy;
  logic [DW-1:0]    rd_data;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_re;
  logic             mem_we;
  logic [DW-1:0]    mem_rdata;

  int checks;
  int errors;

  mem_arbiter #(
    .NPORTS (NP),
    .AW     (AW),
    .DW     (DW)
  ) dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .rdy       (rdy),
    .rd_data   (rd_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram [0:65535];

  always @(posedge sys_clk) begin
    if (!reset_n) begin
      sram[16'h0010] <= 16'hBEEF;
      mem_rdata      <= '0;
    end else begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= sram[mem_addr];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] d);
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
    req_rd[p]             = rd;
    req_wr[p]             = wr;
  endtask

  task automatic clr_port(input int p);
    req_rd[p] = 1'b0;
    req_wr[p] = 1'b0;
  endtask

  task automatic clr_all();
    req_rd = '0;
    req_wr = '0;
  endtask

  task automatic next_cyc();
    @(negedge sys_clk);
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_rd    = '0;
    req_wr    = '0;

    // reset state
    next_cyc(); #1;
    chk("rst_rdy", 32'(rdy), 32'h0);
    chk("rst_re", 32'(mem_re), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    next_cyc();
    reset_n = 1'b1;

    // single port read, no contention
    next_cyc();
    set_port(1, 1'b1, 1'b0, 16'h0010, 16'h0000); #1;
    chk("t1_re", 32'(mem_re), 32'h1);
    chk("t1_addr", 32'(mem_addr), 32'h0010);
    chk("t1_rdy_early", 32'(rdy), 32'h0);
    next_cyc(); #1;
    chk("t1_rdy", 32'(rdy), 32'b010);
    chk("t1_rd_data", 32'(rd_data), 32'hBEEF);
    chk("t1_masked", 32'(mem_re), 32'h0);
    next_cyc(); clr_all(); #1;
    chk("t1_single_rdy", 32'(rdy), 32'h0);
    chk("t1_hold", 32'(rd_data), 32'hBEEF);

    // wrap: pointer at 2, ports 0 and 2 write
    next_cyc();
    set_port(2, 1'b0, 1'b1, 16'h0200, 16'hA2A2);
    set_port(0, 1'b0, 1'b1, 16'h0201, 16'hA0A0); #1;
    chk("t4_first_addr", 32'(mem_addr), 32'(T4_ADDR_A));
    chk("t4_first_we", 32'(mem_we), 32'h1);
    next_cyc(); #1;
    chk("t4_rdy_a", 32'(rdy), 32'(T4_RDY_A));
    chk("t4_second_addr", 32'(mem_addr), 32'(T4_ADDR_B));
    next_cyc(); clr_port(T4_FIRST); #1;
    chk("t4_rdy_b", 32'(rdy), 32'(T4_RDY_B));
    chk("t4_idle_we", 32'(mem_we), 32'h0);
    next_cyc(); clr_all(); #1;
    chk("t4_sram_p2", 32'(sram[16'h0200]), 32'hA2A2);
    chk("t4_sram_p0", 32'(sram[16'h0201]), 32'hA0A0);

    // pointer after the wrap: ports 0 and 1 together
    next_cyc();
    set_port(0, 1'b0, 1'b1, 16'h0300, 16'h5050);
    set_port(1, 1'b0, 1'b1, 16'h0301, 16'h6161); #1;
    chk("t4_ptr_addr", 32'(mem_addr), 32'(PC_ADDR_A));
    next_cyc();
    next_cyc(); clr_port(PC_FIRST);
    next_cyc(); clr_all();

    // held request on a sole requester
    next_cyc();
    set_port(2, 1'b0, 1'b1, 16'h0400, 16'h4444); #1;
    chk("t3_c0_rdy", 32'(rdy), 32'h0);
    chk("t3_c0_we", 32'(mem_we), 32'h1);
    chk("t3_c0_addr", 32'(mem_addr), 32'h0400);
    next_cyc(); #1;
    chk("t3_c1_rdy", 32'(rdy), 32'b100);
    chk("t3_c1_we", 32'(mem_we), 32'h0);
    next_cyc(); #1;
    chk("t3_c2_rdy", 32'(rdy), 32'h0);
    chk("t3_c2_we", 32'(mem_we), 32'h1);
    next_cyc(); #1;
    chk("t3_c3_rdy", 32'(rdy), 32'b100);
    chk("t3_c3_we", 32'(mem_we), 32'h0);
    next_cyc(); clr_all();

    // contention: all three write from pointer 0
    next_cyc();
    set_port(0, 1'b0, 1'b1, 16'h0100, 16'h1111);
    set_port(1, 1'b0, 1'b1, 16'h0101, 16'h2222);
    set_port(2, 1'b0, 1'b1, 16'h0102, 16'h3333); #1;
    chk("t2_c0_addr", 32'(mem_addr), 32'h0100);
    chk("t2_c0_rdy", 32'(rdy), 32'h0);
    next_cyc(); #1;
    chk("t2_c1_rdy", 32'(rdy), 32'b001);
    chk("t2_c1_addr", 32'(mem_addr), 32'h0101);
    next_cyc(); clr_port(0); #1;
    chk("t2_c2_rdy", 32'(rdy), 32'b010);
    chk("t2_c2_addr", 32'(mem_addr), 32'h0102);
    chk("t2_c2_wdata", 32'(mem_wdata), 32'h3333);
    next_cyc(); clr_port(1); #1;
    chk("t2_c3_rdy", 32'(rdy), 32'b100);
    chk("t2_c3_we", 32'(mem_we), 32'h0);
    next_cyc(); clr_all(); #1;
    chk("t2_sram0", 32'(sram[16'h0100]), 32'h1111);
    chk("t2_sram1", 32'(sram[16'h0101]), 32'h2222);
    chk("t2_sram2", 32'(sram[16'h0102]), 32'h3333);
    chk("t3_sram", 32'(sram[16'h0400]), 32'h4444);

    // priority: ports 1,2 read continuously, port 0 joins at cycle 5
    next_cyc();
    set_port(1, 1'b1, 1'b0, 16'h0101, 16'h0000);
    set_port(2, 1'b1, 1'b0, 16'h0102, 16'h0000); #1;
    chk("t5_c0_re", 32'(mem_re), 32'h1);
    next_cyc(); #1;
    chk("t5_c1_rdy", 32'(rdy), 32'b010);
    chk("t5_c1_rd_data", 32'(rd_data), 32'h2222);
    next_cyc(); #1;
    chk("t5_c2_rdy", 32'(rdy), 32'b100);
    chk("t5_c2_rd_data", 32'(rd_data), 32'h3333);
    next_cyc();
    next_cyc();
    next_cyc();
    set_port(0, 1'b0, 1'b1, 16'h0500, 16'h5555); #1;
    chk("t5_c5_addr", 32'(mem_addr), 32'(T5_ADDR_5));
    next_cyc(); #1;
    chk("t5_c6_addr", 32'(mem_addr), 32'(T5_ADDR_6));
    chk("t5_c6_rdy", 32'(rdy), 32'(T5_RDY_6));
    next_cyc(); clr_all(); #1;
    chk("t5_c7_idle_re", 32'(mem_re), 32'h0);
    chk("t5_c7_idle_we", 32'(mem_we), 32'h0);
    next_cyc(); #1;
    chk("t5_sram", 32'(sram[16'h0500]), 32'h5555);

    // read and write together on one port: write wins, one rdy
    next_cyc();
    set_port(1, 1'b1, 1'b1, 16'h0600, 16'h6666); #1;
    chk("rw_we", 32'(mem_we), 32'h1);
    chk("rw_re", 32'(mem_re), 32'h0);
    next_cyc(); #1;
    chk("rw_rdy", 32'(rdy), 32'b010);
    chk("rw_rd_data_hold", 32'(rd_data), 32'h3333);
    next_cyc(); clr_all(); #1;
    chk("rw_single_rdy", 32'(rdy), 32'h0);
    chk("rw_sram", 32'(sram[16'h0600]), 32'h6666);

    // reset with a pending rdy
    next_cyc();
    set_port(1, 1'b0, 1'b1, 16'h0700, 16'h7777);
    next_cyc(); #1;
    chk("t6_pending_rdy", 32'(rdy), 32'b010);
    reset_n = 1'b0;
    set_port(0, 1'b1, 1'b0, 16'h0100, 16'h0000);
    set_port(1, 1'b1, 1'b0, 16'h0101, 16'h0000);
    set_port(2, 1'b1, 1'b0, 16'h0102, 16'h0000); #1;
    chk("t6_rdy_async", 32'(rdy), 32'h0);
    chk("t6_we_async", 32'(mem_we), 32'h0);
    chk("t6_re_async", 32'(mem_re), 32'h0);
    chk("t6_rd_data", 32'(rd_data), 32'h0);
    next_cyc();
    reset_n = 1'b1; #1;
    chk("t6_ptr0_addr", 32'(mem_addr), 32'h0100);
    chk("t6_ptr0_re", 32'(mem_re), 32'h1);
    next_cyc(); #1;
    chk("t6_after_rdy", 32'(rdy), 32'b001);
    chk("t6_after_rd_data", 32'(rd_data), 32'h1111);
    next_cyc(); clr_all();
    next_cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
